// File: rtl/dpram_port_arbiter_if.sv
// dpram_port_arbiter_if: client request bundle plus the shared RAM port for dpram_port_arbiter
interface dpram_port_arbiter_if #(
    parameter int address_width = 10,
    parameter int data_width = 8
);
    logic [2:0] client_req;
    logic [2:0] client_wren;
    logic [3*address_width-1:0] client_address;
    logic [3*data_width-1:0] client_data;
    logic [2:0] client_ack;
    logic [data_width-1:0] client_q;
    logic [2:0] client_q_valid;
    logic ram_wren;
    logic [address_width-1:0] ram_address;
    logic [data_width-1:0] ram_data;
    logic [data_width-1:0] ram_q;
    modport slave (
        input client_req, client_wren, client_address, client_data, ram_q,
        output client_ack, client_q, client_q_valid, ram_wren, ram_address, ram_data
    );
    modport master (
        output client_req, client_wren, client_address, client_data, ram_q,
        input client_ack, client_q, client_q_valid, ram_wren, ram_address, ram_data
    );
endinterface

// File: rtl/dpram_port_arbiter.sv
// dpram_port_arbiter: shares one synchronous RAM port between three clients (round-robin or fixed priority)
module dpram_port_arbiter #(
    parameter int address_width = 10,
    parameter int data_width = 8,
    parameter bit fixed_priority = 1'b0
) (
    input logic clk,
    input logic reset,
    dpram_port_arbiter_if.slave bus
);
    logic [2:0] eligible, rd_pend, rd_pend_d;
    logic [1:0] last, first, second, grant;
    always_comb begin
        eligible = bus.client_req & ~bus.client_ack;
        first = fixed_priority ? 2'd0 : (last == 2'd2 ? 2'd0 : last + 2'd1);
        second = first == 2'd2 ? 2'd0 : first + 2'd1;
        grant = eligible[first] ? first : eligible[second] ? second : (second == 2'd2 ? 2'd0 : second + 2'd1);
    end
    // read results follow the ack by two edges: one for the RAM, one to register q
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.client_ack <= 3'b000;
            bus.client_q_valid <= 3'b000;
            bus.client_q <= '0;
            bus.ram_wren <= 1'b0;
            bus.ram_address <= '0;
            bus.ram_data <= '0;
            last <= 2'd2;
            rd_pend <= 3'b000;
            rd_pend_d <= 3'b000;
        end else begin
            bus.client_ack <= |eligible ? 3'b001 << grant : 3'b000;
            bus.ram_wren <= |eligible && bus.client_wren[grant];
            rd_pend <= (|eligible && !bus.client_wren[grant]) ? 3'b001 << grant : 3'b000;
            rd_pend_d <= rd_pend;
            bus.client_q_valid <= rd_pend_d;
            if (|eligible) begin
                bus.ram_address <= bus.client_address[grant*address_width +: address_width];
                bus.ram_data <= bus.client_data[grant*data_width +: data_width];
                last <= grant;
            end
            if (|rd_pend_d) bus.client_q <= bus.ram_q;
        end
    end
endmodule

// File: tb/tb_dpram_port_arbiter.sv
// tb_dpram_port_arbiter: directed scenarios plus a randomized run against a behavioural arbiter model
module tb_dpram_port_arbiter;
    localparam int aw = 10;
    localparam int dw = 8;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_checks = 0;
    int n_fail = 0;
    logic [dw-1:0] mem_r [1024];
    logic [dw-1:0] mem_f [1024];

    dpram_port_arbiter_if #(.address_width(aw), .data_width(dw)) br ();
    dpram_port_arbiter_if #(.address_width(aw), .data_width(dw)) bf ();
    dpram_port_arbiter #(.address_width(aw), .data_width(dw), .fixed_priority(1'b0)) u_rr (
        .clk(clk), .reset(reset), .bus(br));
    dpram_port_arbiter #(.address_width(aw), .data_width(dw), .fixed_priority(1'b1)) u_fx (
        .clk(clk), .reset(reset), .bus(bf));

    always #5 clk = ~clk;

    // synchronous RAM ports, one-cycle read latency
    always @(posedge clk) begin
        if (br.ram_wren) mem_r[br.ram_address] <= br.ram_data;
        br.ram_q <= mem_r[br.ram_address];
        if (bf.ram_wren) mem_f[bf.ram_address] <= bf.ram_data;
        bf.ram_q <= mem_f[bf.ram_address];
    end

    task automatic drive_r(input int i, input logic rq, input logic wr, input logic [aw-1:0] a, input logic [dw-1:0] d);
        br.client_req[i] = rq;
        br.client_wren[i] = wr;
        br.client_address[i*aw +: aw] = a;
        br.client_data[i*dw +: dw] = d;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        br.client_req = '0;
        bf.client_req = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({br.client_ack, br.client_q_valid, br.client_q, br.ram_wren, br.ram_address, br.ram_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_rr: ack=%b qv=%b q=%h wren=%b addr=%h data=%h, required all 0",
                     br.client_ack, br.client_q_valid, br.client_q, br.ram_wren, br.ram_address, br.ram_data);
        end
        n_checks++;
        if ({bf.client_ack, bf.client_q_valid, bf.client_q, bf.ram_wren, bf.ram_address, bf.ram_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_fx: ack=%b qv=%b q=%h wren=%b addr=%h data=%h, required all 0",
                     bf.client_ack, bf.client_q_valid, bf.client_q, bf.ram_wren, bf.ram_address, bf.ram_data);
        end
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_checks++;
            if (br.ram_wren !== 1'b0 || br.client_ack !== 3'b000) begin
                n_fail++;
                $display("FAIL idle cycle %0d: wren=%b ack=%b, required 0 and 000", k, br.ram_wren, br.client_ack);
            end
        end
    endtask

    task automatic test_write_read();
        drive_r(1, 1'b1, 1'b1, 10'h123, 8'h5a);
        @(negedge clk);
        n_checks++;
        if ({br.client_ack, br.ram_wren, br.ram_address, br.ram_data} !== {3'b010, 1'b1, 10'h123, 8'h5a}) begin
            n_fail++;
            $display("FAIL wr_ack: ack=%b wren=%b addr=%h data=%h, required 010 1 123 5a",
                     br.client_ack, br.ram_wren, br.ram_address, br.ram_data);
        end
        drive_r(1, 1'b0, 1'b1, 10'h123, 8'h5a);
        @(negedge clk);
        n_checks++;
        if ({br.client_ack, br.ram_wren} !== 4'b0000) begin
            n_fail++;
            $display("FAIL wr_single_pulse: ack=%b wren=%b, required 000 0", br.client_ack, br.ram_wren);
        end
        drive_r(1, 1'b1, 1'b0, 10'h123, 8'h00);
        @(negedge clk);
        n_checks++;
        if ({br.client_ack, br.ram_wren, br.ram_address} !== {3'b010, 1'b0, 10'h123}) begin
            n_fail++;
            $display("FAIL rd_ack: ack=%b wren=%b addr=%h, required 010 0 123", br.client_ack, br.ram_wren, br.ram_address);
        end
        drive_r(1, 1'b0, 1'b0, 10'h123, 8'h00);
        @(negedge clk);
        n_checks++;
        if (br.client_q_valid !== 3'b000) begin
            n_fail++;
            $display("FAIL rd_early: qv=%b, required 000", br.client_q_valid);
        end
        @(negedge clk);
        n_checks++;
        if ({br.client_q_valid, br.client_q} !== {3'b010, 8'h5a}) begin
            n_fail++;
            $display("FAIL rd_data: qv=%b q=%h, required 010 5a", br.client_q_valid, br.client_q);
        end
        @(negedge clk);
        n_checks++;
        if ({br.client_q_valid, br.client_q} !== {3'b000, 8'h5a}) begin
            n_fail++;
            $display("FAIL q_hold: qv=%b q=%h, required 000 5a", br.client_q_valid, br.client_q);
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] e_ack, e_qv;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) drive_r(i, 1'b1, 1'b0, 10'h123, 8'h00);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            e_ack = 3'b001 << ((k - 1) % 3);
            e_qv = k >= 3 ? 3'b001 << ((k - 3) % 3) : 3'b000;
            n_checks++;
            if (br.client_ack !== e_ack || br.client_q_valid !== e_qv || (k >= 3 && br.client_q !== 8'h5a)) begin
                n_fail++;
                $display("FAIL rr_order cycle %0d: ack=%b qv=%b q=%h, required %b %b 5a",
                         k, br.client_ack, br.client_q_valid, br.client_q, e_ack, e_qv);
            end
        end
        for (int i = 0; i < 3; i++) drive_r(i, 1'b0, 1'b0, 10'h123, 8'h00);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_hold_through_ack();
        drive_r(0, 1'b1, 1'b1, 10'h200, 8'h33);
        @(negedge clk);
        n_checks++;
        if ({br.client_ack, br.ram_wren, br.ram_address} !== {3'b001, 1'b1, 10'h200}) begin
            n_fail++;
            $display("FAIL hold_ack: ack=%b wren=%b addr=%h, required 001 1 200", br.client_ack, br.ram_wren, br.ram_address);
        end
        @(negedge clk);
        n_checks++;
        if ({br.client_ack, br.ram_wren} !== 4'b0000) begin
            n_fail++;
            $display("FAIL hold_no_regrant: ack=%b wren=%b, required 000 0", br.client_ack, br.ram_wren);
        end
        drive_r(0, 1'b0, 1'b1, 10'h200, 8'h33);
        @(negedge clk);
        n_checks++;
        if ({br.client_ack, br.ram_wren} !== 4'b0000) begin
            n_fail++;
            $display("FAIL hold_idle: ack=%b wren=%b, required 000 0", br.client_ack, br.ram_wren);
        end
    endtask

    task automatic test_fixed_priority();
        logic [2:0] e;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bf.client_wren = '0;
        bf.client_address = '0;
        bf.client_data = '0;
        bf.client_req = 3'b101;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            e = k % 2 == 0 ? 3'b001 : 3'b100;
            n_checks++;
            if (bf.client_ack !== e) begin
                n_fail++;
                $display("FAIL fx_0_2 cycle %0d: ack=%b, required %b", k, bf.client_ack, e);
            end
        end
        bf.client_req = 3'b111;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            e = k % 2 == 0 ? 3'b001 : 3'b010;
            n_checks++;
            if (bf.client_ack !== e) begin
                n_fail++;
                $display("FAIL fx_0_1 cycle %0d: ack=%b, required %b", k, bf.client_ack, e);
            end
        end
        bf.client_req = 3'b000;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid_read();
        drive_r(2, 1'b1, 1'b0, 10'h123, 8'h00);
        @(negedge clk);
        n_checks++;
        if (br.client_ack !== 3'b100) begin
            n_fail++;
            $display("FAIL mid_ack: ack=%b, required 100", br.client_ack);
        end
        reset = 1'b1;
        drive_r(2, 1'b0, 1'b0, 10'h123, 8'h00);
        @(negedge clk);
        n_checks++;
        if ({br.client_ack, br.client_q_valid, br.client_q, br.ram_wren, br.ram_address, br.ram_data} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: ack=%b qv=%b q=%h wren=%b addr=%h data=%h, required all 0",
                     br.client_ack, br.client_q_valid, br.client_q, br.ram_wren, br.ram_address, br.ram_data);
        end
        reset = 1'b0;
        drive_r(0, 1'b1, 1'b0, 10'h123, 8'h00);
        drive_r(2, 1'b1, 1'b0, 10'h123, 8'h00);
        @(negedge clk);
        n_checks++;
        if ({br.client_ack, br.client_q_valid} !== {3'b001, 3'b000}) begin
            n_fail++;
            $display("FAIL mid_first_winner: ack=%b qv=%b, required 001 000", br.client_ack, br.client_q_valid);
        end
        drive_r(0, 1'b0, 1'b0, 10'h123, 8'h00);
        @(negedge clk);
        n_checks++;
        if ({br.client_ack, br.client_q_valid} !== {3'b100, 3'b000}) begin
            n_fail++;
            $display("FAIL mid_no_stale_valid: ack=%b qv=%b, required 100 000", br.client_ack, br.client_q_valid);
        end
        drive_r(2, 1'b0, 1'b0, 10'h123, 8'h00);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_random();
        int m_last, g;
        logic [2:0] m_ack, elig, new_v, exp_qv, p0v, p1v, pr_req, pr_wr;
        logic [dw-1:0] new_d, p0d, p1d, m_q, m_data;
        logic [aw-1:0] m_addr;
        logic m_wren;
        logic [dw-1:0] exp_mem [16];
        bit known [16];
        bit active [3];
        int waited [3];
        logic op_wr [3];
        logic [aw-1:0] op_addr [3];
        logic [dw-1:0] op_data [3];
        logic [aw-1:0] pr_addr [3];
        logic [dw-1:0] pr_data [3];
        m_last = 2;
        m_ack = '0; p0v = '0; p1v = '0; pr_req = '0; pr_wr = '0;
        p0d = '0; p1d = '0; m_q = '0; m_data = '0; m_addr = '0; m_wren = 1'b0;
        for (int a = 0; a < 16; a++) begin
            exp_mem[a] = '0;
            known[a] = 1'b0;
        end
        for (int i = 0; i < 3; i++) begin
            active[i] = 1'b0; waited[i] = 0; op_wr[i] = 1'b0; op_addr[i] = '0; op_data[i] = '0;
            pr_addr[i] = '0; pr_data[i] = '0;
            drive_r(i, 1'b0, 1'b0, '0, '0);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            // model: eligible requests, round-robin from the client after the last winner
            elig = pr_req & ~m_ack;
            g = -1;
            for (int j = 0; j < 3; j++) if (g < 0 && elig[(m_last + 1 + j) % 3]) g = (m_last + 1 + j) % 3;
            m_ack = '0;
            m_wren = 1'b0;
            new_v = '0;
            new_d = '0;
            if (g >= 0) begin
                m_ack[g] = 1'b1;
                m_wren = pr_wr[g];
                m_addr = pr_addr[g];
                m_data = pr_data[g];
                m_last = g;
                if (pr_wr[g]) begin
                    exp_mem[m_addr[3:0]] = m_data;
                    known[m_addr[3:0]] = 1'b1;
                end else begin
                    new_v[g] = 1'b1;
                    new_d = exp_mem[m_addr[3:0]];
                end
            end
            exp_qv = p1v;
            if (p1v != 3'b000) m_q = p1d;
            p1v = p0v; p1d = p0d; p0v = new_v; p0d = new_d;
            n_checks++;
            if ({br.client_ack, br.client_q_valid, br.client_q} !== {m_ack, exp_qv, m_q}) begin
                n_fail++;
                $display("FAIL rnd_client cycle %0d: ack=%b qv=%b q=%h, required %b %b %h",
                         cyc, br.client_ack, br.client_q_valid, br.client_q, m_ack, exp_qv, m_q);
            end
            n_checks++;
            if ({br.ram_wren, br.ram_address, br.ram_data} !== {m_wren, m_addr, m_data}) begin
                n_fail++;
                $display("FAIL rnd_ram cycle %0d: wren=%b addr=%h data=%h, required %b %h %h",
                         cyc, br.ram_wren, br.ram_address, br.ram_data, m_wren, m_addr, m_data);
            end
            for (int i = 0; i < 3; i++) begin
                if (active[i]) begin
                    waited[i]++;
                    if (br.client_ack[i] || waited[i] > 4) begin
                        n_checks++;
                        if (!br.client_ack[i]) begin
                            n_fail++;
                            $display("FAIL rnd_wait client %0d: waited %0d cycles without ack, required <= 4", i, waited[i]);
                        end
                        active[i] = 1'b0;
                    end
                end
                if (!active[i] && $urandom_range(0, 1) == 0) begin
                    active[i] = 1'b1;
                    waited[i] = 0;
                    op_addr[i] = aw'($urandom_range(0, 15));
                    op_wr[i] = known[op_addr[i][3:0]] ? 1'($urandom_range(0, 1)) : 1'b1;
                    op_data[i] = dw'($urandom);
                end
                drive_r(i, active[i], op_wr[i], op_addr[i], op_data[i]);
                pr_req[i] = active[i];
                pr_wr[i] = op_wr[i];
                pr_addr[i] = op_addr[i];
                pr_data[i] = op_data[i];
            end
        end
        for (int i = 0; i < 3; i++) drive_r(i, 1'b0, 1'b0, '0, '0);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        br.client_req = '0; br.client_wren = '0; br.client_address = '0; br.client_data = '0;
        bf.client_req = '0; bf.client_wren = '0; bf.client_address = '0; bf.client_data = '0;
        test_reset();
        test_write_read();
        test_round_robin();
        test_hold_through_ack();
        test_fixed_priority();
        test_reset_mid_read();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
